// File: rtl/sk_demod_pkg.sv
// -----------------------------------------------------------------------------
// sk_demod_pkg
// Shared definitions for the coherent integrate-and-dump PSK/ASK demodulator:
// mode encodings, the controller state type and a helper that gives the
// narrowest accumulator that can hold a full bit period without overflow.
// -----------------------------------------------------------------------------
package sk_demod_pkg;

    // Same encoding as the modulator flag_mod LSB in its keyed modes
    localparam logic MODE_PSK = 1'b0;
    localparam logic MODE_ASK = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A 16-bit signed term summed bit_cycles times needs 17 bits of headroom
    // plus log2 of the number of terms.
    function automatic int acc_width_min(input int bit_cycles);
        return 17 + $clog2(bit_cycles);
    endfunction

endpackage

// File: rtl/sk_integrate_dump.sv
// -----------------------------------------------------------------------------
// sk_integrate_dump
// Per-sample term generation, accumulator and bit-period cycle counter.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   clear      : zero the accumulator and cycle counter this cycle
//   enable     : accumulate the current sample (controller is in RUN)
//   mode       : latched mode, MODE_PSK or MODE_ASK
//   sig        : signed modulated sample
//   carrier    : signed coherent carrier reference
//   sum        : acc + term for the current sample (combinational)
//   dump       : current sample is the last of the bit period (combinational)
// -----------------------------------------------------------------------------
module sk_integrate_dump
    import sk_demod_pkg::*;
#(
    parameter int BIT_CYCLES = 10000,
    parameter int ACC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             mode,
    input  logic [7:0]       sig,
    input  logic [7:0]       carrier,
    output logic [ACC_W-1:0] sum,
    output logic             dump
);

    localparam logic [15:0] LAST_CYC = 16'(BIT_CYCLES - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      cyc_cnt_q, cyc_cnt_d;

    logic signed [15:0] prod;
    logic [7:0]         mag;
    logic [15:0]        term;
    logic [ACC_W-1:0]   term_ext;

    // Term select. The product of two 8-bit signed values always fits in
    // 16 signed bits. The ASK magnitude is kept as an unsigned 8-bit value so
    // that |-128| comes out as 128 rather than wrapping negative.
    always_comb begin
        prod     = $signed(sig) * $signed(carrier);
        mag      = sig[7] ? (~sig + 8'd1) : sig;
        term     = (mode == MODE_ASK) ? {8'd0, mag} : prod;
        term_ext = {{(ACC_W-16){term[15]}}, term};
        sum      = acc_q + term_ext;
        dump     = enable && (cyc_cnt_q == LAST_CYC);
    end

    // Accumulate while enabled; the last sample of a period empties the
    // accumulator so the next period starts with no gap.
    always_comb begin
        acc_d     = acc_q;
        cyc_cnt_d = cyc_cnt_q;
        if (clear) begin
            acc_d     = '0;
            cyc_cnt_d = '0;
        end else if (enable) begin
            if (dump) begin
                acc_d     = '0;
                cyc_cnt_d = '0;
            end else begin
                acc_d     = sum;
                cyc_cnt_d = cyc_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cyc_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

endmodule

// File: rtl/sk_demod.sv
// -----------------------------------------------------------------------------
// sk_demod
// Coherent integrate-and-dump demodulator for the PSK/ASK test signal.
// Recovers one bit per BIT_CYCLES samples.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   start      : pulse, begins or re-aligns bit timing (latches mode)
//   stop       : pulse, returns to IDLE (wins over start)
//   mode       : 0 = PSK, 1 = ASK
//   sig        : signed modulated sample
//   carrier    : signed coherent carrier reference
//   threshold  : unsigned ASK decision threshold
//   bit_out    : last decided bit
//   bit_valid  : one-cycle strobe when bit_out is new
//   busy       : high while running
//   bit_cnt    : bits decided since the last start (wrapping)
// -----------------------------------------------------------------------------
module sk_demod
    import sk_demod_pkg::*;
#(
    parameter int BIT_CYCLES = 10000,
    parameter int ACC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [7:0]       sig,
    input  logic [7:0]       carrier,
    input  logic [ACC_W-1:0] threshold,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic [15:0]      bit_cnt
);

    // Reject parameter sets where a full period could overflow the accumulator
    // or the 16-bit cycle counter.
    generate
        if (ACC_W < acc_width_min(BIT_CYCLES)) begin : g_acc_w_check
            $error("sk_demod: ACC_W too narrow for BIT_CYCLES");
        end
        if (BIT_CYCLES < 2 || BIT_CYCLES > 65535) begin : g_bit_cycles_check
            $error("sk_demod: BIT_CYCLES out of range 2..65535");
        end
    endgenerate

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;

    logic             clear;
    logic             enable;
    logic [ACC_W-1:0] sum;
    logic             dump;

    sk_integrate_dump #(
        .BIT_CYCLES (BIT_CYCLES),
        .ACC_W      (ACC_W)
    ) u_int (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .enable  (enable),
        .mode    (mode_q),
        .sig     (sig),
        .carrier (carrier),
        .sum     (sum),
        .dump    (dump)
    );

    // Control and decision. A start in either state clears the integrator,
    // so the sample presented with start is never accumulated. Stop always
    // beats start, and any partial period is discarded without a strobe.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        clear       = 1'b0;
        enable      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = RUN;
                    mode_d    = mode;
                    bit_cnt_d = '0;
                    clear     = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else if (start) begin
                    mode_d    = mode;
                    bit_cnt_d = '0;
                    clear     = 1'b1;
                end else begin
                    enable = 1'b1;
                    if (dump) begin
                        bit_valid_d = 1'b1;
                        bit_cnt_d   = bit_cnt_q + 16'd1;
                        // PSK: negative correlation means an inverted carrier,
                        // i.e. bit 1. ASK: energy at or above threshold.
                        if (mode_q == MODE_PSK) begin
                            bit_out_d = sum[ACC_W-1];
                        end else begin
                            bit_out_d = (sum >= threshold);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_PSK;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign busy      = (state_q == RUN);
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_sk_demod.sv
// -----------------------------------------------------------------------------
// tb_sk_demod
// Directed bench for sk_demod with a short bit period. Expected decisions are
// produced by a behavioural model and queued when a period is driven; a
// monitor pops them whenever the DUT strobes bit_valid.
// -----------------------------------------------------------------------------
module tb_sk_demod;
    import sk_demod_pkg::*;

    localparam int BC    = 16;
    localparam int ACC_W = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             mode;
    logic [7:0]       sig;
    logic [7:0]       carrier;
    logic [ACC_W-1:0] threshold;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic [15:0]      bit_cnt;

    typedef struct {
        logic        b;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int          checks   = 0;
    int          failures = 0;
    logic        tb_mode  = MODE_PSK;
    logic [15:0] exp_cnt  = '0;

    sk_demod #(
        .BIT_CYCLES (BC),
        .ACC_W      (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .sig       (sig),
        .carrier   (carrier),
        .threshold (threshold),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .bit_cnt   (bit_cnt)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decision for a period of constant samples
    function automatic logic modelBit(input logic m, input logic signed [7:0] s,
                                      input logic signed [7:0] c,
                                      input logic [31:0] thr);
        longint total = 0;
        for (int i = 0; i < BC; i++) begin
            if (m == MODE_PSK) total += longint'(s) * longint'(c);
            else               total += (s < 0) ? -longint'(s) : longint'(s);
        end
        if (m == MODE_PSK) return (total < 0);
        return (total >= longint'(thr));
    endfunction

    // Drive n samples. With full set, the last one must close a period:
    // bit_valid low after every earlier sample and high after the last.
    task automatic applyStimulus(input logic signed [7:0] s, input logic signed [7:0] c,
                                 input int n, input bit full);
        exp_t e;
        if (full) begin
            exp_cnt = exp_cnt + 16'd1;
            e.b     = modelBit(tb_mode, s, c, threshold);
            e.cnt   = exp_cnt;
            sb.push_back(e);
        end
        sig     = s;
        carrier = c;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (full && i == n) checkOutput("strobe_at_end", {31'd0, bit_valid}, 32'd1);
            else                checkOutput("no_strobe", {31'd0, bit_valid}, 32'd0);
        end
    endtask

    task automatic issueStart(input logic m);
        mode    = m;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tb_mode = m;
        exp_cnt = '0;
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_bit_cnt", {16'd0, bit_cnt}, 32'd0);
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bit_valid === 1'b1) begin : mon
            exp_t e;
            if (sb.size() == 0) begin
                checkOutput("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("bit_out", {31'd0, bit_out}, {31'd0, e.b});
                checkOutput("bit_cnt", {16'd0, bit_cnt}, {16'd0, e.cnt});
                checkOutput("busy_at_strobe", {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = MODE_PSK;
        sig       = '0;
        carrier   = '0;
        threshold = '0;
        $display("[TB] reset");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_valid", {31'd0, bit_valid}, 32'd0);
        checkOutput("reset_bit_out", {31'd0, bit_out}, 32'd0);
        checkOutput("reset_bit_cnt", {16'd0, bit_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] PSK periods");
        issueStart(MODE_PSK);
        applyStimulus(8'sd64, 8'sd64, BC, 1'b1);
        applyStimulus(-8'sd64, 8'sd64, BC, 1'b1);
        applyStimulus(-8'sd64, 8'sd64, BC, 1'b1);

        $display("[TB] ASK periods, re-start from RUN, mode change ignored");
        threshold = 32'd800;
        issueStart(MODE_ASK);
        mode = MODE_PSK;
        applyStimulus(8'sd100, 8'sd77, BC, 1'b1);
        applyStimulus(8'sd0, 8'sd77, BC, 1'b1);
        applyStimulus(-8'sd50, 8'sd77, BC, 1'b1);
        applyStimulus(-8'sd128, 8'sd77, BC, 1'b1);
        threshold = 32'd801;
        applyStimulus(-8'sd50, 8'sd77, BC, 1'b1);

        $display("[TB] re-align mid period");
        threshold = 32'd0;
        issueStart(MODE_PSK);
        applyStimulus(8'sd64, 8'sd64, 10, 1'b0);
        issueStart(MODE_PSK);
        applyStimulus(-8'sd64, 8'sd64, BC, 1'b1);

        $display("[TB] stop mid period");
        applyStimulus(8'sd64, 8'sd64, 5, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop_busy", {31'd0, busy}, 32'd0);
        checkOutput("stop_bit_out_hold", {31'd0, bit_out}, 32'd1);
        checkOutput("stop_bit_cnt_hold", {16'd0, bit_cnt}, 32'd1);
        applyStimulus(8'sd64, 8'sd64, 20, 1'b0);

        $display("[TB] start and stop together");
        start = 1'b1;
        stop  = 1'b1;
        tick();
        checkOutput("idle_start_stop_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        stop  = 1'b0;
        issueStart(MODE_PSK);
        applyStimulus(8'sd64, 8'sd64, 3, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("run_start_stop_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'sd64, 8'sd64, 20, 1'b0);

        $display("[TB] reset mid RUN with start");
        issueStart(MODE_PSK);
        applyStimulus(-8'sd64, 8'sd64, BC, 1'b1);
        applyStimulus(-8'sd64, 8'sd64, 5, 1'b0);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_bit_out", {31'd0, bit_out}, 32'd0);
        checkOutput("rst_bit_cnt", {16'd0, bit_cnt}, 32'd0);
        checkOutput("rst_valid", {31'd0, bit_valid}, 32'd0);
        applyStimulus(-8'sd64, 8'sd64, 20, 1'b0);

        tick();
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sk_demod.md
Name: sk_demod

Overview:
- Coherent integrate-and-dump demodulator for the 10 kbps PSK/ASK test signal produced by the sine generator.
- Takes the 8-bit signed modulated stream and a phase-aligned 8-bit signed carrier reference.
- Recovers one bit per bit period.
- Sits on the receive/loopback path and feeds a bit checker against the transmit LFSR sequence.

Parameters:
- BIT_CYCLES, 10000, clocks per bit period (10 kbps at 100 MHz); legal range 2..65535.
- ACC_W, 32, accumulator width; must be >= 17 + clog2(BIT_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins or re-aligns bit timing.
- stop  in  1  single-cycle pulse; returns to IDLE.
- mode  in  1  0 = PSK, 1 = ASK; same encoding as the modulator flag_mod LSB in 2'b11 modes.
- sig  in  8  signed modulated sample, one per clk.
- carrier  in  8  signed coherent carrier reference, one per clk.
- threshold  in  ACC_W  unsigned ASK decision threshold.
- bit_out  out  1  last decided bit.
- bit_valid  out  1  one-cycle strobe; bit_out is new.
- busy  out  1  high in RUN.
- bit_cnt  out  16  bits decided since last start; wraps 65535 -> 0.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; acc, cyc_cnt, bit_cnt, bit_out, bit_valid and busy all 0; mode_q 0. Reset overrides start and stop.
- States: IDLE, RUN.
  - IDLE -> RUN on start. mode_q <= mode. acc, cyc_cnt and bit_cnt cleared. busy=1 from the next cycle.
  - RUN -> IDLE on stop. acc and cyc_cnt cleared; bit_out holds; no bit_valid generated.
  - RUN + start: re-align. acc, cyc_cnt and bit_cnt cleared; mode_q reloaded; no bit_valid for the discarded partial period.
  - start and stop in the same cycle: stop wins.
- Per-cycle term, RUN only:
  - PSK: term = sig * carrier, 16-bit signed product.
  - ASK: term = |sig| zero-extended; |-128| = 128, so no overflow.
  - Sign-extend term to ACC_W.
- First accumulated sample is the one presented the cycle after start.
- Each RUN cycle: sum = acc + term.
  - If cyc_cnt < BIT_CYCLES-1: acc <= sum; cyc_cnt++.
  - If cyc_cnt == BIT_CYCLES-1 (dump):
    - acc <= 0; cyc_cnt <= 0; bit_cnt++; bit_valid <= 1.
    - PSK: bit_out <= (sum < 0). An inverted carrier means bit 1, matching the modulator's sig_sk=1 negation.
    - ASK: bit_out <= (sum >= threshold), unsigned compare.
- Periods are back-to-back with no idle gap.
- Latency: bit_valid and bit_out update on the clk edge that consumes the last sample of the period, so they are visible one cycle after that sample is presented.
- bit_valid is high exactly one cycle per period and never in IDLE.
- mode changes mid-RUN are ignored until the next start.
- The accumulator never overflows within legal parameters, so no saturation logic.

Decomposition:
- Package sk_demod_pkg:
  - MODE_PSK=1'b0, MODE_ASK=1'b1.
  - state enum {IDLE, RUN}.
  - function acc_width_min(bit_cycles), used in an elaboration-time check on ACC_W.
- One sub-module, sk_integrate_dump. It holds the term select, accumulator, cycle counter and dump strobe. The top holds the FSM, decision and bit counter.

Test Plan:
- BIT_CYCLES=16, PSK, start; sig=carrier=+64 for 16 cycles -> sum=65536; bit_valid one cycle after the 16th sample, bit_out=0, bit_cnt=1.
- PSK, sig=-64 and carrier=+64 for periods 2-3 -> two bit_valid strobes 16 cycles apart, bit_out=1 each, bit_cnt=3; bit_valid high exactly 1 cycle of every 16.
- ASK, threshold=800; sig=+100 for one period, then 0 -> bit_out=1 (sum 1600), then bit_out=0 (sum 0); sig=-50 for one period -> sum 800 -> bit_out=1 (>= boundary).
- ASK, sig=-128 constant -> sum 2048, bit_out=1. Confirms |-128| = 128.
- start re-issued at cycle 10 of a period -> no bit_valid at cycle 16; next strobe 16 cycles after the new start; bit_cnt resets. stop mid-period -> busy=0, no strobe, bit_out holds.
- rst asserted mid-RUN with start high in the same cycle -> IDLE, all outputs 0 next cycle. Loopback against the modulator output (BIT_CYCLES=10000, 1 MHz carrier) -> recovered bits equal the LFSR sequence after one period of latency.
